// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter. A request is granted 1 edge later when arbitration is allowed.
// The grant is frozen while HREADY=0, inside a fixed burst, or during a locked sequence.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

    logic [NUM_MASTERS-1:0] grant_q;
    logic [3:0]             beats_left;
    logic [3:0]             beats_left_next;
    logic [3:0]             burst_last;
    logic [MW-1:0]          gidx;
    logic [MW-1:0]          win;
    logic [MW-1:0]          cand;
    logic                   found;
    logic                   arb_ok;

    assign HGRANT = grant_q;

    // Beats remaining after the NONSEQ beat; SINGLE and INCR never hold the bus.
    always_comb begin
        case (HBURST)
            3'b010, 3'b011: burst_last = 4'd3;
            3'b100, 3'b101: burst_last = 4'd7;
            3'b110, 3'b111: burst_last = 4'd15;
            default:        burst_last = 4'd0;
        endcase
    end

    always_comb begin
        beats_left_next = beats_left;
        if (HRESP != RESP_OKAY) begin
            beats_left_next = 4'd0;
        end else if (HREADY) begin
            case (HTRANS)
                TR_NONSEQ: beats_left_next = burst_last;
                TR_SEQ:    beats_left_next = (beats_left != 4'd0) ? beats_left - 4'd1 : beats_left;
                TR_IDLE:   beats_left_next = 4'd0;
                TR_BUSY:   beats_left_next = beats_left;
                default:   beats_left_next = beats_left;
            endcase
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) gidx = MW'(i);
        end
    end

    // The current owner is visited last, so it only keeps the bus when nobody else asks.
    always_comb begin
        win   = MW'(DEFAULT_MASTER);
        found = 1'b0;
        cand  = gidx;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = MW'((int'(gidx) + k) % NUM_MASTERS);
            if (!found && HBUSREQ[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // HMASTLOCK term gives one extra hold edge so the last locked data phase finishes first.
    assign arb_ok = HREADY && (beats_left_next <= 4'd1) && !HLOCK[gidx] && !HMASTLOCK;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_q    <= ONE << DEFAULT_MASTER;
            HMASTER    <= MW'(DEFAULT_MASTER);
            HMASTLOCK  <= 1'b0;
            beats_left <= 4'd0;
        end else begin
            beats_left <= beats_left_next;
            if (arb_ok) begin
                grant_q <= ONE << win;
            end
            if (HREADY) begin
                HMASTER   <= gidx;
                HMASTLOCK <= HLOCK[gidx];
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios against literal expectations, then random
// traffic against an integer-state reference model of the arbitration rules.
module tb_ahb_arbiter;

    localparam int N   = 4;
    localparam int DEF = 0;

    logic         HCLK;
    logic         HRESET;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic         HREADY;
    logic [1:0]   HRESP;
    logic [N-1:0] HGRANT;
    logic [1:0]   HMASTER;
    logic         HMASTLOCK;

    int errors = 0;
    int checks = 0;

    // Reference model state: owner indices as integers, beat count as integer.
    int m_grant;
    int m_master;
    int m_beats;
    bit m_mlock;
    int len_tab [8] = '{1, 0, 4, 4, 8, 8, 16, 16};

    ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic model_reset();
        m_grant  = DEF;
        m_master = DEF;
        m_beats  = 0;
        m_mlock  = 1'b0;
    endtask

    task automatic model_step();
        int  nb;
        int  w;
        bit  permit;
        bit  hit;
        int  len;
        len = len_tab[HBURST];
        if (HRESP != 2'b00)                   nb = 0;
        else if (!HREADY)                     nb = m_beats;
        else if (HTRANS == 2'b10)             nb = (len > 1) ? len - 1 : 0;
        else if (HTRANS == 2'b11 && m_beats > 0) nb = m_beats - 1;
        else if (HTRANS == 2'b00)             nb = 0;
        else                                  nb = m_beats;
        permit = HREADY && (nb <= 1) && !HLOCK[2'(m_grant)] && !m_mlock;
        w = m_grant;
        if (permit) begin
            w   = DEF;
            hit = 1'b0;
            for (int off = 1; off <= N; off++) begin
                if (!hit && HBUSREQ[2'((m_grant + off) % N)]) begin
                    w   = (m_grant + off) % N;
                    hit = 1'b1;
                end
            end
        end
        if (HREADY) begin
            m_master = m_grant;
            m_mlock  = HLOCK[2'(m_grant)];
        end
        m_grant = w;
        m_beats = nb;
    endtask

    task automatic tick();
        @(posedge HCLK);
        if (HRESET) model_reset();
        else        model_step();
        #1;
    endtask

    task automatic quiet_inputs();
        HBUSREQ = '0;
        HLOCK   = '0;
        HTRANS  = 2'b00;
        HBURST  = 3'b000;
        HREADY  = 1'b1;
        HRESP   = 2'b00;
    endtask

    task automatic test_reset();
        quiet_inputs();
        HRESET = 1'b1;
        model_reset();
        tick();
        tick();
        checks++;
        if (HGRANT !== 4'b0001) begin
            errors++;
            $display("FAIL reset_grant: got %b expected 0001", HGRANT);
        end
        HRESET = 1'b0;
        HBUSREQ = 4'b0100;
        tick();
        tick();
        // Assert reset between edges; outputs must return without any clock edge.
        #3;
        HRESET = 1'b1;
        model_reset();
        #2;
        checks++;
        if (HGRANT !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset_grant: got %b expected 0001", HGRANT);
        end
        checks++;
        if (HMASTER !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_master: got %0d expected 0", HMASTER);
        end
        checks++;
        if (HMASTLOCK !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mastlock: got %b expected 0", HMASTLOCK);
        end
        #1;
        HRESET = 1'b0;
        quiet_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
        logic [1:0] exp_m [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        HBUSREQ = 4'b1110;
        HTRANS  = 2'b10;
        HBURST  = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (HGRANT !== exp_g[i]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", i, HGRANT, exp_g[i]);
            end
            checks++;
            if (HMASTER !== exp_m[i]) begin
                errors++;
                $display("FAIL rr_master[%0d]: got %0d expected %0d", i, HMASTER, exp_m[i]);
            end
        end
    endtask

    task automatic test_burst_hold();
        logic [3:0] exp_g [3] = '{4'b0010, 4'b0010, 4'b0100};
        HBUSREQ = 4'b0010;
        HTRANS  = 2'b00;
        tick();
        checks++;
        if (HGRANT !== 4'b0010 || HMASTER !== 2'd1) begin
            errors++;
            $display("FAIL burst_setup: got grant %b master %0d expected 0010/1", HGRANT, HMASTER);
        end
        HBUSREQ = 4'b0110;
        HTRANS  = 2'b10;
        HBURST  = 3'b011;
        for (int i = 0; i < 3; i++) begin
            tick();
            HTRANS = 2'b11;
            checks++;
            if (HGRANT !== exp_g[i]) begin
                errors++;
                $display("FAIL burst_grant[beat %0d]: got %b expected %b", i + 1, HGRANT, exp_g[i]);
            end
        end
        HBUSREQ = 4'b0100;
        tick();
        checks++;
        if (HMASTER !== 2'd2 || HGRANT !== 4'b0100) begin
            errors++;
            $display("FAIL burst_handover: got master %0d grant %b expected 2/0100", HMASTER, HGRANT);
        end
    endtask

    task automatic test_stall();
        HBUSREQ = 4'b1000;
        HTRANS  = 2'b00;
        HBURST  = 3'b000;
        tick();
        checks++;
        if (HGRANT !== 4'b1000) begin
            errors++;
            $display("FAIL stall_grant: got %b expected 1000", HGRANT);
        end
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (HMASTER !== 2'd2 || HGRANT !== 4'b1000) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got master %0d grant %b expected 2/1000", i, HMASTER, HGRANT);
            end
        end
        HREADY = 1'b1;
        tick();
        checks++;
        if (HMASTER !== 2'd3) begin
            errors++;
            $display("FAIL stall_release: got master %0d expected 3", HMASTER);
        end
    endtask

    task automatic test_lock();
        HBUSREQ = 4'b0100;
        HLOCK   = 4'b0100;
        HTRANS  = 2'b00;
        tick();
        HBUSREQ = 4'b0101;
        HTRANS  = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (HGRANT !== 4'b0100) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got %b expected 0100", i, HGRANT);
            end
        end
        checks++;
        if (HMASTLOCK !== 1'b1 || HMASTER !== 2'd2) begin
            errors++;
            $display("FAIL lock_mastlock: got lock %b master %0d expected 1/2", HMASTLOCK, HMASTER);
        end
        HLOCK   = 4'b0000;
        HBUSREQ = 4'b0001;
        tick();
        checks++;
        if (HGRANT !== 4'b0100) begin
            errors++;
            $display("FAIL lock_extra_hold: got %b expected 0100", HGRANT);
        end
        tick();
        checks++;
        if (HGRANT !== 4'b0001) begin
            errors++;
            $display("FAIL lock_release: got %b expected 0001", HGRANT);
        end
    endtask

    task automatic test_early_term();
        HBUSREQ = 4'b0001;
        HTRANS  = 2'b00;
        tick();
        HBUSREQ = 4'b0011;
        HTRANS  = 2'b10;
        HBURST  = 3'b101;
        tick();
        HTRANS = 2'b11;
        tick();
        tick();
        checks++;
        if (HGRANT !== 4'b0001) begin
            errors++;
            $display("FAIL incr8_hold: got %b expected 0001", HGRANT);
        end
        HRESP  = 2'b01;
        HREADY = 1'b0;
        tick();
        checks++;
        if (HGRANT !== 4'b0001 || dut.beats_left !== 4'd0) begin
            errors++;
            $display("FAIL error_first: got grant %b beats %0d expected 0001/0", HGRANT, dut.beats_left);
        end
        HREADY = 1'b1;
        HTRANS = 2'b00;
        tick();
        checks++;
        if (HGRANT !== 4'b0010) begin
            errors++;
            $display("FAIL error_second: got %b expected 0010", HGRANT);
        end
        HRESP   = 2'b00;
        HBUSREQ = 4'b0000;
        tick();
        checks++;
        if (HGRANT !== 4'b0001 || HMASTER !== 2'd1) begin
            errors++;
            $display("FAIL park: got grant %b master %0d expected 0001/1", HGRANT, HMASTER);
        end
    endtask

    task automatic test_random();
        HLOCK = '0;
        for (int it = 0; it < 600; it++) begin
            HBUSREQ = 4'($urandom);
            if ($urandom_range(0, 7) == 0)
                HLOCK = 4'($urandom) & 4'($urandom) & 4'($urandom);
            HTRANS = 2'($urandom);
            HBURST = 3'($urandom);
            HREADY = ($urandom_range(0, 4) != 0);
            HRESP  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (it == 300) begin
                #2;
                HRESET = 1'b1;
                model_reset();
                #1;
                checks++;
                if (HGRANT !== 4'b0001 || HMASTER !== 2'd0) begin
                    errors++;
                    $display("FAIL rand_async_reset: got grant %b master %0d expected 0001/0", HGRANT, HMASTER);
                end
                HRESET = 1'b0;
            end
            tick();
            checks++;
            if (HGRANT !== 4'(1 << m_grant)) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %b expected %b", it, HGRANT, 4'(1 << m_grant));
            end
            checks++;
            if (HMASTER !== 2'(m_master)) begin
                errors++;
                $display("FAIL rand_master[%0d]: got %0d expected %0d", it, HMASTER, m_master);
            end
            checks++;
            if (HMASTLOCK !== m_mlock) begin
                errors++;
                $display("FAIL rand_mastlock[%0d]: got %b expected %b", it, HMASTLOCK, m_mlock);
            end
            checks++;
            if (!$onehot(HGRANT)) begin
                errors++;
                $display("FAIL rand_onehot[%0d]: got %b expected one bit set", it, HGRANT);
            end
        end
    endtask

    initial begin
        HRESET = 1'b1;
        quiet_inputs();
        model_reset();
        test_reset();
        test_round_robin();
        test_burst_hold();
        test_stall();
        test_lock();
        test_early_term();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
